mc_bram_responder: RTL and testbench
====================================

# mc_bram_responder

Memory-controller-side responder that terminates the arbiter's MC request interface (`data_rden`/`data_wren`/`data_addr`/`data_wr` in; `data_rd`/`mc_rd_valid`/`mc_wr_rdy`/`mc_rd_rdy` out). It is backed by an on-chip 256-bit-wide register array with programmable read and write latency. It stands in for the DDR2 controller on the FPGA checker build, so the arbiter and caches can be exercised without external memory. Requests are level-held by the initiator until completion; the responder services exactly one request at a time.

## Interface
- `ADDR_W`, default 10: word-address width; the array holds 2^ADDR_W words of 256 bits.
- `RD_LAT`, default 4: cycles from read acceptance to `mc_rd_valid`; legal range 1..15.
- `WR_LAT`, default 2: cycles from write acceptance to the write-completion `mc_wr_rdy`; legal range 1..15.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_wr`  in  256  write data.
- `data_addr`  in  31  word address.
- `data_rden`  in  1  read request, held high until `mc_rd_valid` is seen.
- `data_wren`  in  1  write request, held high until `mc_wr_rdy` is seen.
- `data_rd`  out  256  read data; valid while `mc_rd_valid` is high, held afterwards.
- `mc_rd_valid`  out  1  one-cycle read-completion pulse.
- `mc_wr_rdy`  out  1  high while idle or on write completion; low while busy.
- `mc_rd_rdy`  out  1  high only in IDLE.
- `err`  out  1  sticky protocol/range error.
- `rd_count`  out  32  completed reads (see Configuration).
- `wr_count`  out  32  completed writes (see Configuration).

## Operation
- FSM states: IDLE, WR_WAIT, RD_WAIT, RELEASE.
- IDLE: `mc_wr_rdy`=1, `mc_rd_rdy`=1. On a sampled `data_wren`, latch address and data, set `cnt`=WR_LAT-1, drop `mc_wr_rdy` and `mc_rd_rdy`, and go to WR_WAIT. Else on a sampled `data_rden`, latch address, set `cnt`=RD_LAT-1, drop both ready outputs, and go to RD_WAIT.
- Both `data_wren` and `data_rden` high in IDLE: the write is serviced, the read is ignored, and `err` is set.
- WR_WAIT: while `cnt`≠0, decrement. At `cnt`=0, write the latched data to the array, raise `mc_wr_rdy`, and go to RELEASE.
- RD_WAIT: while `cnt`≠0, decrement. At `cnt`=0, load `data_rd` from the array, pulse `mc_rd_valid` for one cycle, and go to RELEASE.
- RELEASE: `mc_wr_rdy`=1, `mc_rd_rdy`=0, `mc_rd_valid`=0. Remain here until `data_rden`=0 and `data_wren`=0 in the same cycle, then go to IDLE. This blocks re-triggering by a request the initiator has not yet dropped.
- Range check: the array index is `data_addr[ADDR_W-1:0]`. If any bit `data_addr[30:ADDR_W]` is 1:
  - Writes are dropped but still complete normally.
  - Reads return 256'd0.
  - `err` is set in both cases.
- Request inputs changing during WR_WAIT or RD_WAIT are ignored, because address and data are latched at acceptance.
- `err` clears only on reset.
- Array contents are not reset and are undefined until written.

## Timing
- All outputs are registered.
- Write accepted at edge T: `mc_wr_rdy` is low for cycles T+1..T+WR_LAT and high from T+WR_LAT+1 onward. Array contents are updated at edge T+WR_LAT.
- Read accepted at edge T: `mc_rd_valid`=1 during exactly one cycle, T+RD_LAT+1, with `data_rd` valid in that cycle.
- Minimum back-to-back spacing: one RELEASE cycle with both requests low, then one IDLE cycle to accept the next request.
- Reset values: `data_rd`=0, `mc_rd_valid`=0, `mc_wr_rdy`=1, `mc_rd_rdy`=1, `err`=0, `rd_count`=0, `wr_count`=0, state=IDLE.
- Reset asserted mid-operation: the in-flight request is abandoned. A pending write is not committed.

## Configuration
- Macro `MC_RESP_STATS_EN`.
- Defined: `rd_count` and `wr_count` increment on each read and write completion, including out-of-range ones. They wrap modulo 2^32.
- Undefined: both ports are present but tied to 32'd0, and no counter logic is built.

## Test plan
- Write 0xA5…A5 to address 5, then read address 5 (defaults). Required:
  - `mc_wr_rdy` low for 2 cycles, then high.
  - `mc_rd_valid` pulses 5 cycles after read acceptance with `data_rd`=0xA5…A5.
  - With `MC_RESP_STATS_EN`: `wr_count`=1, `rd_count`=1.
- Hold `data_rden` high for 3 cycles after `mc_rd_valid`. Required: exactly one `mc_rd_valid` pulse; FSM stays in RELEASE until `data_rden` drops.
- Read address 0x400 with ADDR_W=10. Required: `data_rd`=0, `mc_rd_valid` pulses, `err`=1.
- Raise `data_wren` and `data_rden` together at address 3 with data 0x1. Required:
  - The write completes and no `mc_rd_valid` occurs.
  - `err`=1.
  - A subsequent read of address 3 returns 0x1.
- Assert `reset` low during WR_WAIT for a write of 0xFF to address 7, where address 7 was previously written with 0x0. Required: outputs return to reset values immediately; a later read of address 7 returns 0x0.
- Set RD_LAT=1 and WR_LAT=1. Required: `mc_wr_rdy` low for exactly 1 cycle; `mc_rd_valid` 2 cycles after acceptance.

Source files
------------

// File: rtl/mc_bram_responder.sv
// Memory-controller responder backed by an on-chip 256-bit register array with programmable latency.
// Optional read/write completion counters are built when MC_RESP_STATS_EN is defined.
module mc_bram_responder #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] data_wr,
    input  logic [30:0]  data_addr,
    input  logic         data_rden,
    input  logic         data_wren,
    output logic [255:0] data_rd,
    output logic         mc_rd_valid,
    output logic         mc_wr_rdy,
    output logic         mc_rd_rdy,
    output logic         err,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WR_WAIT = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT - 1);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);

    logic [1:0]        state_q,    state_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [255:0]      wdata_q,    wdata_d;
    logic              oor_q,      oor_d;
    logic [255:0]      data_rd_q,  data_rd_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_rdy_q,   wr_rdy_d;
    logic              rd_rdy_q,   rd_rdy_d;
    logic              err_q,      err_d;

    logic [255:0]      mem [DEPTH];
    logic              mem_we;
    logic              addr_oor;

    // Any set bit above the array index makes the request out of range.
    assign addr_oor = |(data_addr >> ADDR_W);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        oor_d      = oor_q;
        data_rd_d  = data_rd_q;
        rd_valid_d = 1'b0;
        wr_rdy_d   = wr_rdy_q;
        rd_rdy_d   = rd_rdy_q;
        err_d      = err_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_rdy_d = 1'b1;
                rd_rdy_d = 1'b1;
                if (data_wren) begin
                    addr_d   = data_addr[ADDR_W-1:0];
                    wdata_d  = data_wr;
                    oor_d    = addr_oor;
                    cnt_d    = WR_CNT_INIT;
                    wr_rdy_d = 1'b0;
                    rd_rdy_d = 1'b0;
                    state_d  = S_WR_WAIT;
                    // A simultaneous read is dropped in favour of the write.
                    if (data_rden || addr_oor) begin
                        err_d = 1'b1;
                    end
                end else if (data_rden) begin
                    addr_d   = data_addr[ADDR_W-1:0];
                    oor_d    = addr_oor;
                    cnt_d    = RD_CNT_INIT;
                    wr_rdy_d = 1'b0;
                    rd_rdy_d = 1'b0;
                    state_d  = S_RD_WAIT;
                    if (addr_oor) begin
                        err_d = 1'b1;
                    end
                end
            end

            S_WR_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we   = !oor_q;
                    wr_rdy_d = 1'b1;
                    state_d  = S_RELEASE;
                end
            end

            S_RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_rd_d  = oor_q ? 256'd0 : mem[addr_q];
                    rd_valid_d = 1'b1;
                    wr_rdy_d   = 1'b1;
                    state_d    = S_RELEASE;
                end
            end

            S_RELEASE: begin
                wr_rdy_d = 1'b1;
                rd_rdy_d = 1'b0;
                // Wait for the initiator to drop its request so it cannot retrigger.
                if (!data_rden && !data_wren) begin
                    rd_rdy_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            oor_q      <= 1'b0;
            data_rd_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_rdy_q   <= 1'b1;
            rd_rdy_q   <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            oor_q      <= oor_d;
            data_rd_q  <= data_rd_d;
            rd_valid_q <= rd_valid_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_rdy_q   <= rd_rdy_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign data_rd     = data_rd_q;
    assign mc_rd_valid = rd_valid_q;
    assign mc_wr_rdy   = wr_rdy_q;
    assign mc_rd_rdy   = rd_rdy_q;
    assign err         = err_q;

`ifdef MC_RESP_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        rd_done;
    logic        wr_done;

    // Completions include out-of-range requests; counters wrap naturally.
    assign rd_done = (state_q == S_RD_WAIT) && (cnt_q == 4'd0);
    assign wr_done = (state_q == S_WR_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_done) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (wr_done) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mc_bram_responder.sv
// Self-checking bench for mc_bram_responder: a table of directed requests on a default-latency
// instance plus hand-written reset-abort and minimum-latency sequences.
module tb_mc_bram_responder;

    localparam logic [255:0] PA5 = {32{8'hA5}};
    localparam logic [255:0] P9  = {4{64'hDEAD_BEEF_0123_4567}};
    localparam logic [255:0] P1  = {8{32'h1111_2222}};
    localparam logic [255:0] P2  = {16{16'hC3E1}};
    localparam logic [255:0] PFF = {256{1'b1}};

    typedef struct {
        logic         wr;
        logic         rd;
        logic [30:0]  addr;
        logic [255:0] wdata;
        int           hold;
        logic [255:0] exp_rd;
        logic         exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         wren     [2];
    logic         rden     [2];
    logic [30:0]  addr     [2];
    logic [255:0] wdata    [2];
    logic [255:0] rdata_o  [2];
    logic         rd_valid [2];
    logic         wr_rdy   [2];
    logic         rd_rdy   [2];
    logic         err_o    [2];
    logic [31:0]  rdc      [2];
    logic [31:0]  wrc      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_bram_responder dut (
        .clk         (clk),
        .reset       (reset),
        .data_wr     (wdata[0]),
        .data_addr   (addr[0]),
        .data_rden   (rden[0]),
        .data_wren   (wren[0]),
        .data_rd     (rdata_o[0]),
        .mc_rd_valid (rd_valid[0]),
        .mc_wr_rdy   (wr_rdy[0]),
        .mc_rd_rdy   (rd_rdy[0]),
        .err         (err_o[0]),
        .rd_count    (rdc[0]),
        .wr_count    (wrc[0])
    );

    mc_bram_responder #(.ADDR_W(10), .RD_LAT(1), .WR_LAT(1)) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .data_wr     (wdata[1]),
        .data_addr   (addr[1]),
        .data_rden   (rden[1]),
        .data_wren   (wren[1]),
        .data_rd     (rdata_o[1]),
        .mc_rd_valid (rd_valid[1]),
        .mc_wr_rdy   (wr_rdy[1]),
        .mc_rd_rdy   (rd_rdy[1]),
        .err         (err_o[1]),
        .rd_count    (rdc[1]),
        .wr_count    (wrc[1])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one request on instance i, measuring completion latency in sampled cycles after
    // the acceptance edge, counting read-valid pulses, and checking that RELEASE holds while
    // the request stays up for 'hold' extra cycles.
    task automatic run_req(input int i, input logic wr, input logic rd, input logic [30:0] a,
                           input logic [255:0] d, input int hold, output int lat,
                           output logic [255:0] rdv, output int pulses, output bit rel_ok);
        bit done;
        int w;
        w = 0;
        @(negedge clk);
        while (!rd_rdy[i] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!rd_rdy[i]) check("idle_timeout", {255'd0, rd_rdy[i]}, 256'd1);
        @(posedge clk);
        #1;
        addr[i]  = a;
        wdata[i] = d;
        wren[i]  = wr;
        rden[i]  = rd;
        @(posedge clk);
        lat    = 0;
        pulses = 0;
        done   = 1'b0;
        rdv    = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rd_valid[i]) begin
                pulses++;
                rdv = rdata_o[i];
            end
            done = wr ? wr_rdy[i] : rd_valid[i];
        end
        if (!done) lat = -1;
        rel_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (rd_valid[i]) pulses++;
            if (rd_rdy[i]) rel_ok = 1'b0;
        end
        wren[i] = 1'b0;
        rden[i] = 1'b0;
        @(negedge clk);
        if (rd_valid[i]) pulses++;
        if (!rd_rdy[i]) rel_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [12];
        int           lat;
        int           pulses;
        bit           rel_ok;
        logic [255:0] rdv;
        logic [31:0]  exp_rdc;
        logic [31:0]  exp_wrc;

        vecs[0]  = '{wr:1'b1, rd:1'b0, addr:31'd5,     wdata:PA5,    hold:0, exp_rd:'0,     exp_err:1'b0};
        vecs[1]  = '{wr:1'b0, rd:1'b1, addr:31'd5,     wdata:'0,     hold:3, exp_rd:PA5,    exp_err:1'b0};
        vecs[2]  = '{wr:1'b1, rd:1'b0, addr:31'd9,     wdata:P9,     hold:0, exp_rd:'0,     exp_err:1'b0};
        vecs[3]  = '{wr:1'b1, rd:1'b0, addr:31'd1,     wdata:P1,     hold:1, exp_rd:'0,     exp_err:1'b0};
        vecs[4]  = '{wr:1'b1, rd:1'b0, addr:31'd7,     wdata:'0,     hold:0, exp_rd:'0,     exp_err:1'b0};
        vecs[5]  = '{wr:1'b0, rd:1'b1, addr:31'd9,     wdata:'0,     hold:0, exp_rd:P9,     exp_err:1'b0};
        vecs[6]  = '{wr:1'b0, rd:1'b1, addr:31'd5,     wdata:'0,     hold:0, exp_rd:PA5,    exp_err:1'b0};
        vecs[7]  = '{wr:1'b0, rd:1'b1, addr:31'h400,   wdata:'0,     hold:0, exp_rd:256'd0, exp_err:1'b1};
        vecs[8]  = '{wr:1'b1, rd:1'b0, addr:31'h401,   wdata:PFF,    hold:0, exp_rd:'0,     exp_err:1'b1};
        vecs[9]  = '{wr:1'b0, rd:1'b1, addr:31'd1,     wdata:'0,     hold:0, exp_rd:P1,     exp_err:1'b1};
        vecs[10] = '{wr:1'b1, rd:1'b1, addr:31'd3,     wdata:256'd1, hold:0, exp_rd:'0,     exp_err:1'b1};
        vecs[11] = '{wr:1'b0, rd:1'b1, addr:31'd3,     wdata:'0,     hold:0, exp_rd:256'd1, exp_err:1'b1};

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wren[i]  = 1'b0;
            rden[i]  = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
        end
        exp_rdc = 32'd0;
        exp_wrc = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_rd",  rdata_o[0], 256'd0);
        check("rst_rd_valid", {255'd0, rd_valid[0]}, 256'd0);
        check("rst_wr_rdy",   {255'd0, wr_rdy[0]},   256'd1);
        check("rst_rd_rdy",   {255'd0, rd_rdy[0]},   256'd1);
        check("rst_err",      {255'd0, err_o[0]},    256'd0);
        check("rst_rd_count", {224'd0, rdc[0]},      256'd0);
        check("rst_wr_count", {224'd0, wrc[0]},      256'd0);
        check("rst_fast_wr_rdy", {255'd0, wr_rdy[1]}, 256'd1);
        reset = 1'b1;

        for (int v = 0; v < 12; v++) begin
            run_req(0, vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].hold,
                    lat, rdv, pulses, rel_ok);
            if (vecs[v].wr) begin
                check($sformatf("v%0d_wr_latency", v), 256'(lat), 256'd3);
                check($sformatf("v%0d_no_rd_pulse", v), 256'(pulses), 256'd0);
                exp_wrc = exp_wrc + 32'd1;
            end else begin
                check($sformatf("v%0d_rd_latency", v), 256'(lat), 256'd5);
                check($sformatf("v%0d_one_pulse", v), 256'(pulses), 256'd1);
                check($sformatf("v%0d_rd_data", v), rdv, vecs[v].exp_rd);
                check($sformatf("v%0d_rd_data_held", v), rdata_o[0], vecs[v].exp_rd);
                exp_rdc = exp_rdc + 32'd1;
            end
            check($sformatf("v%0d_release", v), {255'd0, rel_ok}, 256'd1);
            check($sformatf("v%0d_err", v), {255'd0, err_o[0]}, {255'd0, vecs[v].exp_err});
        end

`ifdef MC_RESP_STATS_EN
        check("table_wr_count", {224'd0, wrc[0]}, {224'd0, exp_wrc});
        check("table_rd_count", {224'd0, rdc[0]}, {224'd0, exp_rdc});
`else
        check("table_wr_count", {224'd0, wrc[0]}, 256'd0);
        check("table_rd_count", {224'd0, rdc[0]}, 256'd0);
`endif

        // Abort a write of all-ones to address 7 while it is still waiting.
        @(negedge clk);
        @(posedge clk);
        #1;
        addr[0]  = 31'd7;
        wdata[0] = PFF;
        wren[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_wr_wait", {255'd0, wr_rdy[0]}, 256'd0);
        reset = 1'b0;
        #1;
        check("abort_wr_rdy",   {255'd0, wr_rdy[0]},   256'd1);
        check("abort_rd_rdy",   {255'd0, rd_rdy[0]},   256'd1);
        check("abort_err",      {255'd0, err_o[0]},    256'd0);
        check("abort_rd_valid", {255'd0, rd_valid[0]}, 256'd0);
        check("abort_data_rd",  rdata_o[0], 256'd0);
        check("abort_wr_count", {224'd0, wrc[0]}, 256'd0);
        wren[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_req(0, 1'b0, 1'b1, 31'd7, '0, 0, lat, rdv, pulses, rel_ok);
        check("abort_readback", rdv, 256'd0);
        check("abort_readback_lat", 256'(lat), 256'd5);
        check("abort_readback_err", {255'd0, err_o[0]}, 256'd0);
`ifdef MC_RESP_STATS_EN
        check("post_reset_rd_count", {224'd0, rdc[0]}, 256'd1);
        check("post_reset_wr_count", {224'd0, wrc[0]}, 256'd0);
`endif

        // Minimum latency instance: write low for one cycle, read valid two cycles on.
        run_req(1, 1'b1, 1'b0, 31'd2, P2, 0, lat, rdv, pulses, rel_ok);
        check("fast_wr_latency", 256'(lat), 256'd2);
        check("fast_wr_release", {255'd0, rel_ok}, 256'd1);
        run_req(1, 1'b0, 1'b1, 31'd2, '0, 2, lat, rdv, pulses, rel_ok);
        check("fast_rd_latency", 256'(lat), 256'd2);
        check("fast_rd_pulses",  256'(pulses), 256'd1);
        check("fast_rd_data",    rdv, P2);
        check("fast_rd_release", {255'd0, rel_ok}, 256'd1);
        check("fast_err",        {255'd0, err_o[1]}, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
